// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NREQ byte-stream requesters.
//   Arbitration is round-robin. A grant stays locked for one packet. The packet
//   ends on req_last, after MAX_BURST bytes, or when the owner leaves req_valid
//   low for IDLE_TIMEOUT cycles. Bytes are handed to the UART through the
//   tx_start/tx_data/tx_busy handshake, so packets from different requesters
//   never interleave.
//
// Optional feature: define ARB_STATS_EN to add the stat_bytes/stat_timeouts
//   counters and their ports.
//
// Ports:
//   clock          system clock
//   resetb         asynchronous active-low reset
//   req_valid      [NREQ]    per-requester byte valid
//   req_data       [8*NREQ]  per-requester byte; requester i on [8i+7:8i]
//   req_last       [NREQ]    final byte of a packet
//   req_ready      [NREQ]    byte accepted this cycle (one-hot or zero)
//   tx_start       one-cycle start pulse to the UART
//   tx_data        [8] byte to the UART, held until the next accept
//   tx_busy        UART is shifting a byte
//   grant_id       [3] current owner, valid while active=1
//   active         a grant is held
//   stat_bytes     [16] saturating count of accepted bytes (ARB_STATS_EN)
//   stat_timeouts  [8]  saturating count of idle-timeout releases (ARB_STATS_EN)
//
// state   | meaning
// IDLE    | no owner; scan req_valid from rr_ptr for the next grant
// SEND    | owner presented req_ready; waiting for its req_valid
// WAIT_HI | tx_start issued; waiting for the UART to raise tx_busy
// WAIT_LO | UART shifting; waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [2:0]        grant_id,
  output logic              active
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_bytes,
  output logic [7:0]        stat_timeouts
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  localparam logic [3:0] NREQ_W     = 4'(NREQ);
  localparam logic [2:0] LAST_ID    = 3'(NREQ - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [9:0] IDLE_LAST  = 10'(IDLE_TIMEOUT - 1);

  state_t     state;
  logic [2:0] rr_ptr;
  logic [7:0] byte_cnt;
  logic [9:0] idle_cnt;
  logic       last_flag;

  // Requester vectors padded to 8 lanes so a 3-bit id indexes them directly
  // for every legal NREQ.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  ready_pad;

  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);

  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  assign sel_valid = valid_pad[grant_id];
  assign sel_last  = last_pad[grant_id];
  assign sel_data  = data_pad[{grant_id, 3'b000} +: 8];

  assign ready_pad = (state == SEND) ? (8'b1 << grant_id) : 8'b0;
  assign req_ready = ready_pad[NREQ-1:0];

  // The first valid requester found scanning cyclically from rr_ptr wins.
  logic       win_found;
  logic [2:0] win_id;
  logic [3:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(i);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!win_found && valid_pad[scan_idx[2:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[2:0];
      end
    end
  end

  logic [2:0] next_ptr;
  logic       accept_stb;
  logic       timeout_stb;

  assign next_ptr    = (grant_id == LAST_ID) ? 3'd0 : grant_id + 3'd1;
  assign accept_stb  = (state == SEND) && sel_valid;
  assign timeout_stb = (state == SEND) && !sel_valid && (idle_cnt >= IDLE_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      last_flag <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id <= win_id;
            active   <= 1'b1;
            byte_cnt <= '0;
            idle_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (accept_stb) begin
            tx_start  <= 1'b1;
            tx_data   <= sel_data;
            byte_cnt  <= byte_cnt + 8'd1;
            last_flag <= sel_last || (byte_cnt == BURST_LAST);
            idle_cnt  <= '0;
            state     <= WAIT_HI;
          end else if (timeout_stb) begin
            state  <= IDLE;
            active <= 1'b0;
            rr_ptr <= next_ptr;
          end else if (idle_cnt != 10'h3FF) begin
            idle_cnt <= idle_cnt + 10'd1;
          end
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_flag) begin
              state  <= IDLE;
              active <= 1'b0;
              rr_ptr <= next_ptr;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      stat_bytes    <= '0;
      stat_timeouts <= '0;
    end else begin
      if (accept_stb && (stat_bytes != 16'hFFFF)) stat_bytes <= stat_bytes + 16'd1;
      if (timeout_stb && (stat_timeouts != 8'hFF)) stat_timeouts <= stat_timeouts + 8'd1;
    end
  end
`endif

endmodule
